// File: rtl/turing_machine_v2.sv
// rtl/turing_machine_v2.sv - parametrised successor Turing-machine engine with a user-loaded rule table
//
// Purpose:
//   Loads a tape and a transition table one symbol-wide chunk at a time
//   through a next/done pin pair. It then runs the machine one step per
//   clock until it halts or faults, and afterwards lets the tape be read
//   back cell by cell.
//
// Optional feature macro: TM_STEP_LIMIT_EN
//   When defined, a step-limit watchdog is built. It faults the machine
//   after MAX_STEPS non-halting steps.
//
// Ports:
//   clock         in   system clock
//   reset         in   synchronous, active-low reset
//   input_data    in   [SYM_W-1:0] tape symbol or rule chunk to load
//   next          in   level; each rising edge is one load/advance action
//   done          in   level; a rising edge ends the tape load
//   display       out  [SYM_W+IDX_W-1:0] {symbol, index} readout
//   compute_done  out  high in HALTED or FAULT
//   fault         out  high in FAULT

module turing_machine_v2 #(
  parameter int SYM_W     = 4,
  parameter int TAPE_LEN  = 64,
  parameter int N_STATES  = 8,
  parameter int MAX_STEPS = 1024
) (
  input  logic                               clock,
  input  logic                               reset,
  input  logic [SYM_W-1:0]                   input_data,
  input  logic                               next,
  input  logic                               done,
  output logic [SYM_W+$clog2(TAPE_LEN)-1:0]  display,
  output logic                               compute_done,
  output logic                               fault
);

  localparam int IDX_W   = $clog2(TAPE_LEN);
  localparam int ST_W    = $clog2(N_STATES);
  localparam int WP_W    = $clog2(TAPE_LEN + 1);
  localparam int ENTRY_W = 2 + SYM_W + ST_W;
  localparam int NIB     = (ENTRY_W + SYM_W - 1) / SYM_W;
  localparam int NIB_W   = (NIB > 1) ? $clog2(NIB) : 1;
  localparam int RIDX_W  = ST_W + SYM_W;
  localparam int N_RULES = N_STATES * (1 << SYM_W);

  typedef enum logic [2:0] {
    S_LOAD_TAPE,
    S_LOAD_RULES,
    S_RUN,
    S_HALTED,
    S_FAULT
  } state_t;

  state_t                   state;
  logic [SYM_W-1:0]         tape [TAPE_LEN];
  logic [ENTRY_W-1:0]       rules [N_RULES];
  logic [WP_W-1:0]          wp;
  logic [SYM_W-1:0]         last_sym;
  logic [RIDX_W-1:0]        rule_idx;
  logic [NIB_W-1:0]         chunk_cnt;
  logic [NIB*SYM_W-1:0]     acc;
  logic [IDX_W-1:0]         head;
  logic [ST_W-1:0]          cur_state;
  logic [IDX_W-1:0]         disp_ptr;
  logic                     next_q;
  logic                     done_q;

  logic                     next_rise;
  logic                     done_rise;
  logic [NIB*SYM_W-1:0]     assembled;
  logic [SYM_W-1:0]         cur_sym;
  logic [RIDX_W-1:0]        rule_addr;
  logic [ENTRY_W-1:0]       entry;
  logic                     e_halt;
  logic                     e_right;
  logic [SYM_W-1:0]         e_wsym;
  logic [ST_W-1:0]          e_ns;
  logic                     off_tape;

  assign next_rise = next & ~next_q;
  assign done_rise = done & ~done_q;

  // The final chunk of an entry is combined straight from the input.
  // As a result, a complete entry is written to the table in one shot.
  always_comb begin
    assembled = acc;
    assembled[(NIB-1)*SYM_W +: SYM_W] = input_data;
  end

  // Bits of the last chunk above ENTRY_W are dropped on purpose.
  logic unused_chunk_bits;
  assign unused_chunk_bits = ^assembled;

  assign cur_sym   = tape[head];
  assign rule_addr = {cur_state, cur_sym};

  // A next_state beyond N_STATES-1 can address a hole in the table.
  // That happens only when N_STATES is not a power of two.
  // Such a lookup is treated as a halt entry.
  assign entry = (int'(rule_addr) < N_RULES) ? rules[rule_addr] : ENTRY_W'(1);

  assign e_halt  = entry[0];
  assign e_right = entry[1];
  assign e_wsym  = entry[SYM_W+1:2];
  assign e_ns    = entry[ENTRY_W-1 -: ST_W];

  assign off_tape = e_right ? (head == IDX_W'(TAPE_LEN - 1)) : (head == '0);

`ifdef TM_STEP_LIMIT_EN
  localparam int STEP_W = $clog2(MAX_STEPS + 1);
  logic [STEP_W-1:0] step_cnt;
`else
  logic unused_max_steps;
  assign unused_max_steps = (MAX_STEPS > 0);
`endif

  always_ff @(posedge clock) begin
    if (!reset) begin
      state        <= S_LOAD_TAPE;
      for (int i = 0; i < TAPE_LEN; i++) tape[i] <= '0;
      for (int i = 0; i < N_RULES; i++) rules[i] <= '0;
      wp           <= '0;
      last_sym     <= '0;
      rule_idx     <= '0;
      chunk_cnt    <= '0;
      acc          <= '0;
      head         <= '0;
      cur_state    <= '0;
      disp_ptr     <= '0;
      next_q       <= 1'b0;
      done_q       <= 1'b0;
      display      <= '0;
      compute_done <= 1'b0;
      fault        <= 1'b0;
`ifdef TM_STEP_LIMIT_EN
      step_cnt     <= '0;
`endif
    end else begin
      next_q <= next;
      done_q <= done;

      // Outputs reflect the state held before this edge.
      // Because of that, they trail every state change by one cycle.
      compute_done <= (state == S_HALTED) || (state == S_FAULT);
      fault        <= (state == S_FAULT);
      case (state)
        S_LOAD_TAPE:  display <= {last_sym, IDX_W'(wp)};
        S_LOAD_RULES: display <= {{SYM_W{1'b0}}, IDX_W'(rule_idx)};
        S_RUN:        display <= {cur_sym, head};
        default:      display <= {tape[disp_ptr], disp_ptr};
      endcase

      case (state)
        S_LOAD_TAPE: begin
          // A write and a done edge in the same cycle both take effect.
          if (next_rise && (wp < WP_W'(TAPE_LEN))) begin
            tape[IDX_W'(wp)] <= input_data;
            last_sym         <= input_data;
            wp               <= wp + 1'b1;
          end
          if (done_rise) begin
            state <= S_LOAD_RULES;
          end
        end

        S_LOAD_RULES: begin
          if (next_rise) begin
            if (chunk_cnt == NIB_W'(NIB - 1)) begin
              rules[rule_idx] <= assembled[ENTRY_W-1:0];
              chunk_cnt       <= '0;
              if (rule_idx == RIDX_W'(N_RULES - 1)) begin
                state     <= S_RUN;
                head      <= '0;
                cur_state <= '0;
              end else begin
                rule_idx <= rule_idx + 1'b1;
              end
            end else begin
              acc[int'(chunk_cnt)*SYM_W +: SYM_W] <= input_data;
              chunk_cnt <= chunk_cnt + 1'b1;
            end
          end
        end

        S_RUN: begin
          if (e_halt) begin
            state <= S_HALTED;
          end else begin
            tape[head] <= e_wsym;
            cur_state  <= e_ns;
            // When the move would leave the tape, the write and state update still happen.
            // Only the head stays where it is.
            if (off_tape) begin
              state <= S_FAULT;
            end else if (e_right) begin
              head <= head + 1'b1;
            end else begin
              head <= head - 1'b1;
            end
`ifdef TM_STEP_LIMIT_EN
            step_cnt <= step_cnt + 1'b1;
            if (step_cnt == STEP_W'(MAX_STEPS - 1)) begin
              state <= S_FAULT;
            end
`endif
          end
        end

        default: begin
          if (next_rise) begin
            disp_ptr <= (disp_ptr == IDX_W'(TAPE_LEN - 1)) ? '0 : disp_ptr + 1'b1;
          end
        end
      endcase
    end
  end

endmodule
